// File: rtl/magnitude_sqrt.sv
// Pipelined restoring square root: floor(sqrt(data_i)) with one result bit per stage.
// Optional MAGNITUDE_SQRT_ROUND_EN: round-to-nearest result through one extra output register.
module magnitude_sqrt #(
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic                   data_clk_i,
    input  logic                   data_rst_i,
    input  logic [2*DATA_SIZE:0]   data_i,
    input  logic                   data_en_i,
    input  logic                   data_sof_i,
    input  logic                   data_eof_i,
    output logic [DATA_SIZE:0]     data_o,
    output logic                   data_en_o,
    output logic                   data_sof_o,
    output logic                   data_eof_o,
    output logic                   data_rst_o,
    output logic                   data_clk_o
);

    localparam int unsigned N  = DATA_SIZE + 1;
    localparam int unsigned RW = DATA_SIZE + 3;
    localparam int unsigned TW = 2 * N;

    logic [RW-1:0] rem  [N];
    logic [N-1:0]  root [N];
    logic [TW-1:0] rad  [N-1];
    logic [N-1:0]  vld;
    logic [N-1:0]  sof;
    logic [N-1:0]  eof;
    logic [TW-1:0] rad_in_c;

    assign data_rst_o = data_rst_i;
    assign data_clk_o = data_clk_i;

    // Odd-width radicand gets one zero MSB so every stage consumes a bit pair.
    assign rad_in_c = {1'b0, data_i};

    // One restoring step: returns {new remainder, new partial root}.
    function automatic logic [RW+N-1:0] step(input logic [RW-1:0] r,
                                             input logic [N-1:0]  q,
                                             input logic [1:0]    b);
        logic [RW+1:0] shifted;
        logic [RW+1:0] sub;
        logic          ge;
        shifted = {r, b};
        sub     = (RW+2)'({q, 2'b01});
        ge      = (shifted >= sub);
        step    = {(ge ? RW'(shifted - sub) : RW'(shifted)), N'({q, ge})};
    endfunction

    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            for (int k = 0; k < N; k++) begin
                rem[k]  <= '0;
                root[k] <= '0;
            end
            for (int k = 0; k < N - 1; k++) begin
                rad[k] <= '0;
            end
            vld <= '0;
            sof <= '0;
            eof <= '0;
        end else begin
            {rem[0], root[0]} <= step(RW'(0), N'(0), rad_in_c[TW-1 -: 2]);
            rad[0] <= {rad_in_c[TW-3:0], 2'b00};
            for (int k = 1; k < N; k++) begin
                {rem[k], root[k]} <= step(rem[k-1], root[k-1], rad[k-1][TW-1 -: 2]);
            end
            for (int k = 1; k < N - 1; k++) begin
                rad[k] <= {rad[k-1][TW-3:0], 2'b00};
            end
            // Frame markers only travel with a valid sample.
            vld <= {vld[N-2:0], data_en_i};
            sof <= {sof[N-2:0], data_sof_i & data_en_i};
            eof <= {eof[N-2:0], data_eof_i & data_en_i};
        end
    end

`ifdef MAGNITUDE_SQRT_ROUND_EN
    logic [N-1:0] rnd_c;
    logic [N-1:0] rnd_val;
    logic         rnd_vld;
    logic         rnd_sof;
    logic         rnd_eof;

    // Remainder above root means x is closer to (root+1)^2 than root^2.
    assign rnd_c = root[N-1] + N'(rem[N-1] > RW'(root[N-1]));

    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            rnd_val <= '0;
            rnd_vld <= 1'b0;
            rnd_sof <= 1'b0;
            rnd_eof <= 1'b0;
        end else begin
            rnd_vld <= vld[N-1];
            rnd_sof <= sof[N-1];
            rnd_eof <= eof[N-1];
            if (vld[N-1]) begin
                rnd_val <= rnd_c;
            end
        end
    end

    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            data_o     <= '0;
            data_en_o  <= 1'b0;
            data_sof_o <= 1'b0;
            data_eof_o <= 1'b0;
        end else begin
            data_en_o  <= rnd_vld;
            data_sof_o <= rnd_sof;
            data_eof_o <= rnd_eof;
            if (rnd_vld) begin
                data_o <= rnd_val;
            end
        end
    end
`else
    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            data_o     <= '0;
            data_en_o  <= 1'b0;
            data_sof_o <= 1'b0;
            data_eof_o <= 1'b0;
        end else begin
            data_en_o  <= vld[N-1];
            data_sof_o <= sof[N-1];
            data_eof_o <= eof[N-1];
            if (vld[N-1]) begin
                data_o <= root[N-1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_magnitude_sqrt.sv
// Scoreboard bench for magnitude_sqrt: directed vectors, expected results queued at issue.
module tb_magnitude_sqrt;

    localparam int unsigned DS = 16;
`ifdef MAGNITUDE_SQRT_ROUND_EN
    localparam int LAT = 18;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 17;
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [DS:0] val;
        logic        sof;
        logic        eof;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [2*DS:0]   data_i = '0;
    logic            en_i = 1'b0;
    logic            sof_i = 1'b0;
    logic            eof_i = 1'b0;
    logic [DS:0]     data_o;
    logic            en_o;
    logic            sof_o;
    logic            eof_o;
    logic            rst_o;
    logic            clk_o;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [DS:0] held = '0;

    magnitude_sqrt #(.DATA_SIZE(DS)) dut (
        .data_clk_i (clk),
        .data_rst_i (rst_n),
        .data_i     (data_i),
        .data_en_i  (en_i),
        .data_sof_i (sof_i),
        .data_eof_i (eof_i),
        .data_o     (data_o),
        .data_en_o  (en_o),
        .data_sof_o (sof_o),
        .data_eof_o (eof_o),
        .data_rst_o (rst_o),
        .data_clk_o (clk_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output pulse, otherwise checks the hold value.
    always @(negedge clk) begin
        exp_t e;
        chk("clk_passthru", longint'(clk_o), longint'(clk));
        chk("rst_passthru", longint'(rst_o), longint'(rst_n));
        if (!rst_n) begin
            chk("reset_en", longint'(en_o), 0);
            chk("reset_data", longint'(data_o), 0);
            held = '0;
        end else if (en_o) begin
            if (q.size() == 0) begin
                chk("unexpected_en", longint'(en_o), 0);
            end else begin
                e = q.pop_front();
                chk("data", longint'(data_o), longint'(e.val));
                chk("sof", longint'(sof_o), longint'(e.sof));
                chk("eof", longint'(eof_o), longint'(e.eof));
                chk("latency_cycle", longint'(cyc), longint'(e.cyc));
                held = e.val;
            end
        end else begin
            chk("hold_data", longint'(data_o), longint'(held));
            chk("idle_sof", longint'(sof_o), 0);
            chk("idle_eof", longint'(eof_o), 0);
        end
    end

    task automatic send(input logic [2*DS:0] x, input bit en, input bit sof,
                        input bit eof, input logic [DS:0] exp_val);
        exp_t e;
        data_i = x;
        en_i   = en;
        sof_i  = sof;
        eof_i  = eof;
        if (en) begin
            e.val = exp_val;
            e.sof = sof;
            e.eof = eof;
            e.cyc = cyc + 1 + LAT;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        en_i  = 1'b0;
        sof_i = 1'b0;
        eof_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout_pending", longint'(q.size()), 0);
        idle(2);
    endtask

    logic [2*DS:0] vx  [5] = '{33'd0, 33'd1, 33'd2, 33'd3, 33'd15};
    logic [DS:0]   vf  [5] = '{17'd0, 17'd1, 17'd1, 17'd1, 17'd3};
    logic [DS:0]   vr  [5] = '{17'd0, 17'd1, 17'd1, 17'd2, 17'd4};

    initial begin
        #2 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(40);

        for (int i = 0; i < 5; i++) begin
            send(vx[i], 1'b1, 1'b0, 1'b0, RND ? vr[i] : vf[i]);
            idle(LAT + 2);
        end
        drain();

        send(33'h1_FFFF_FFFF, 1'b1, 1'b0, 1'b0, RND ? 17'd92682 : 17'd92681);
        send(33'd8589767761, 1'b1, 1'b0, 1'b0, 17'd92681);
        drain();

        // sof/eof without a valid sample must not leak out.
        send(33'd64, 1'b0, 1'b1, 1'b1, 17'd0);
        send(33'd49, 1'b1, 1'b1, 1'b1, 17'd7);
        drain();

        send(33'd16, 1'b1, 1'b1, 1'b0, 17'd4);
        send(33'd25, 1'b1, 1'b0, 1'b0, 17'd5);
        send(33'd36, 1'b1, 1'b0, 1'b1, 17'd6);
        drain();

        send(33'd100, 1'b1, 1'b0, 1'b0, 17'd10);
        send(33'd0,   1'b0, 1'b0, 1'b0, 17'd0);
        send(33'd144, 1'b1, 1'b0, 1'b0, 17'd12);
        send(33'd169, 1'b1, 1'b0, 1'b0, 17'd13);
        send(33'd0,   1'b0, 1'b0, 1'b0, 17'd0);
        send(33'd196, 1'b1, 1'b0, 1'b0, 17'd14);
        drain();

        // Reset with samples in flight: they are discarded, outputs clear at once.
        send(33'd49,  1'b1, 1'b1, 1'b0, 17'd7);
        send(33'd64,  1'b1, 1'b0, 1'b0, 17'd8);
        send(33'd81,  1'b1, 1'b0, 1'b0, 17'd9);
        send(33'd121, 1'b1, 1'b0, 1'b0, 17'd11);
        send(33'd225, 1'b1, 1'b0, 1'b1, 17'd15);
        idle(3);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_reset_data", longint'(data_o), 0);
        chk("async_reset_en", longint'(en_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(33'd400, 1'b1, 1'b0, 1'b0, 17'd20);
        idle(LAT + 20);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
